// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: shift register of in-flight destinations, per-source
// forwarding selects, hazard stall generation and a saturating stall counter.
module forwarding_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 3,
  parameter int FWD_DEPTH  = 2,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1),
  parameter int CNT_W      = 16,
  parameter int EXCLUDE_PC = 1,
  parameter int PC_REG     = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_forwarding,
  input  logic                          freeze,
  input  logic                          flush,
  input  logic                          ex_wb_en,
  input  logic                          ex_mem_read,
  input  logic [REG_ADDR_W-1:0]         ex_dst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          clear_count,
  output logic [NUM_SRC*SEL_W-1:0]      sel_src,
  output logic                          hazard_stall,
  output logic [CNT_W-1:0]              stall_count
);

  // The load flag only matters while the instruction sits in EX, so entries
  // keep just valid and destination.
  logic [FWD_DEPTH-1:0]  sb_valid;
  logic [REG_ADDR_W-1:0] sb_dst [FWD_DEPTH];

  logic [REG_ADDR_W-1:0] src_addr [NUM_SRC];
  logic [NUM_SRC-1:0]    src_ok;
  logic [NUM_SRC-1:0]    ex_hit;
  logic [NUM_SRC-1:0]    early_hit;
  logic [SEL_W-1:0]      sel_arr [NUM_SRC];
  logic                  ex_write;
  logic                  ex_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid <= '0;
      for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
        sb_dst[k] <= '0;
      end
    end else if (!freeze) begin
      sb_valid[0] <= ex_wb_en & ~flush;
      sb_dst[0]   <= ex_dst;
      for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_dst[k]   <= sb_dst[k-1];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_addr[i] = id_src[i*REG_ADDR_W +: REG_ADDR_W];
      src_ok[i]   = id_src_used[i] &&
                    !((EXCLUDE_PC != 0) && (src_addr[i] == REG_ADDR_W'(PC_REG)));
    end
  end

  // Walk oldest to youngest so the youngest matching entry is the last write.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      ex_hit[i]    = src_ok[i] && (src_addr[i] == ex_dst);
      sel_arr[i]   = '0;
      early_hit[i] = 1'b0;
      for (int unsigned kk = FWD_DEPTH; kk > 0; kk--) begin
        if (sb_valid[kk-1] && src_ok[i] && (sb_dst[kk-1] == src_addr[i])) begin
          sel_arr[i] = SEL_W'(kk);
          if (kk < FWD_DEPTH) begin
            early_hit[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    ex_write     = ex_wb_en & ~flush;
    ex_load      = ex_write & ex_mem_read;
    sel_src      = '0;
    hazard_stall = 1'b0;
    if (rst) begin
      if (en_forwarding) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          sel_src[i*SEL_W +: SEL_W] = sel_arr[i];
        end
        hazard_stall = ex_load && (|ex_hit);
      end else begin
        hazard_stall = (ex_write && (|ex_hit)) || (|early_hit);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (clear_count) begin
      stall_count <= '0;
    end else if (hazard_stall && !freeze && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
